// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Reads a run of bytes from an external SPI NOR flash using the 0x03 READ
//   command. SPI mode 0 only, single-bit I/O (io0 = MOSI, io1 = MISO).
//   The returned bytes are presented on a valid/ready stream.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   start_i         request a read; only looked at while idle
//   addr_i, len_i   flash byte address and byte count, latched on accepted start
//   busy_o, done_o  transaction in flight / one-cycle completion pulse
//   data_o, valid_o returned byte stream, held until ready_i
//   ready_i         consumer accepts data_o when valid_o & ready_i
//   flash_csb_o     chip select (active low)
//   flash_clk_o     SCK
//   flash_io0_o     MOSI
//   flash_io1_i     MISO
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int LEN_W    = 16,
    parameter int CSB_IDLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [23:0]      addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             flash_csb_o,
    output logic             flash_clk_o,
    output logic             flash_io0_o,
    input  logic             flash_io1_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(CSB_IDLE + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSB_IDLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic             r_csb;
    logic [31:0]      r_tx;
    logic [6:0]       r_rx;
    logic [4:0]       r_bitCnt;
    logic [LEN_W-1:0] r_remain;
    logic [GAP_W-1:0] r_gapCnt;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic w_active;
    logic w_tick;
    logic w_hold;
    logic w_rise;
    logic w_fall;
    logic w_accept;
    logic w_lastBit;
    logic w_gapDone;

    // At the start of a new data byte, SCK is parked low while the previous
    // byte still waits for the consumer, so at most one byte is ever buffered.
    assign w_active  = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_tick    = w_active && (r_div == DIV_LAST);
    assign w_hold    = (r_state == S_DATA) && !r_sck && (r_bitCnt == 5'd0) && r_valid && !ready_i;
    assign w_rise    = w_tick && !r_sck && !w_hold;
    assign w_fall    = w_tick && r_sck;
    // r_done blocks a start in the completion cycle itself.
    assign w_accept  = (r_state == S_IDLE) && start_i && !r_done;
    assign w_lastBit = ((r_state == S_CMD)  && (r_bitCnt == 5'd7))  ||
                       ((r_state == S_ADDR) && (r_bitCnt == 5'd23)) ||
                       ((r_state == S_DATA) && (r_bitCnt == 5'd7));
    assign w_gapDone = (r_state == S_GAP) && (r_gapCnt == GAP_LAST) && (!r_valid || ready_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; phases advance on the SCK falling edge that ends
    // their last bit. A zero-length request skips the bus entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = (len_i == '0) ? S_GAP : S_CMD;
                end
            end
            S_CMD: begin
                if (w_fall && w_lastBit) begin
                    w_nextState = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_fall && w_lastBit) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_fall && w_lastBit && (r_remain == '0)) begin
                    w_nextState = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gapDone) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // SCK divider, shift registers, byte counter and stream outputs.
    // Command and address share one 32-bit shift register, so io0 is simply
    // its MSB; it is all zeros by the time the data phase starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_sck    <= 1'b0;
            r_csb    <= 1'b1;
            r_tx     <= '0;
            r_rx     <= '0;
            r_bitCnt <= '0;
            r_remain <= '0;
            r_gapCnt <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            if (!w_active) begin
                r_div <= '0;
            end else if (!w_tick) begin
                r_div <= r_div + 1'b1;
            end else if (!w_hold) begin
                r_div <= '0;
            end

            if (w_rise) begin
                r_sck <= 1'b1;
            end else if (w_fall) begin
                r_sck <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_remain <= len_i;
                        r_bitCnt <= '0;
                        r_gapCnt <= '0;
                        r_rx     <= '0;
                        r_csb    <= (len_i == '0);
                        r_tx     <= (len_i == '0) ? 32'h0 : {8'h03, addr_i};
                    end
                end
                S_CMD, S_ADDR: begin
                    if (w_fall) begin
                        r_tx     <= {r_tx[30:0], 1'b0};
                        r_bitCnt <= w_lastBit ? 5'd0 : r_bitCnt + 5'd1;
                    end
                end
                S_DATA: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[5:0], flash_io1_i};
                        if (r_bitCnt == 5'd7) begin
                            r_data   <= {r_rx, flash_io1_i};
                            r_valid  <= 1'b1;
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                    if (w_fall) begin
                        r_bitCnt <= w_lastBit ? 5'd0 : r_bitCnt + 5'd1;
                        if (w_lastBit && (r_remain == '0)) begin
                            r_csb <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gapCnt != GAP_LAST) begin
                        r_gapCnt <= r_gapCnt + 1'b1;
                    end
                    if (w_gapDone) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign flash_csb_o = r_csb;
    assign flash_clk_o = r_sck;
    assign flash_io0_o = r_tx[31];

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader
//   Three reader instances (CLK_DIV = 2, 1, 4) share one set of request and
//   ready inputs. Each has its own small flash model that answers 0x03 READ
//   with a repeating DE AD BE EF pattern, plus per-instance statistics.
module tb_spi_flash_reader;

    localparam int LEN_W = 16;

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          stall;
        int          inject;
        logic [31:0] expMosi;
        int          expRises;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             startI;
    logic [23:0]      addrI;
    logic [LEN_W-1:0] lenI;
    logic             readyI;
    logic             clearStats;
    logic [7:0]       pattern [4];
    int               cycle = 0;
    int               vectors = 0;
    int               miscompares = 0;
    vec_t             vecs [5];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // One DUT per divider setting, each with its own flash model and monitor.
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic        busy, done, valid, csb, sck, io0;
        logic        io1 = 1'b0;
        logic [7:0]  data;
        logic        prevSck = 1'b0;
        logic [31:0] mosi;
        logic [7:0]  rxBytes [16];
        int rises, txRises, rxCount, doneCount, validCycles;
        int csbLowCycles, busyCycles, firstRise, period;

        spi_flash_reader #(.CLK_DIV(DIV), .LEN_W(LEN_W), .CSB_IDLE(2)) dut (
            .clk        (clk),
            .rst        (rst),
            .start_i    (startI),
            .addr_i     (addrI),
            .len_i      (lenI),
            .busy_o     (busy),
            .done_o     (done),
            .data_o     (data),
            .valid_o    (valid),
            .ready_i    (readyI),
            .flash_csb_o(csb),
            .flash_clk_o(sck),
            .flash_io0_o(io0),
            .flash_io1_i(io1)
        );

        // Flash model drives the next MISO bit after each SCK fall once the
        // 32 command/address bits are in; the monitor logs the stream side.
        always @(negedge clk) begin
            if (clearStats) begin
                rises = 0; txRises = 0; rxCount = 0; doneCount = 0; validCycles = 0;
                csbLowCycles = 0; busyCycles = 0; firstRise = 0; period = 0;
                mosi = '0; io1 = 1'b0;
                for (int k = 0; k < 16; k++) rxBytes[k] = 8'h00;
            end else begin
                if (csb) txRises = 0;
                if (sck && !prevSck) begin
                    rises++;
                    if (txRises < 32) mosi = {mosi[30:0], io0};
                    if (txRises == 0) firstRise = cycle;
                    else if (txRises == 1 && period == 0) period = cycle - firstRise;
                    txRises++;
                end
                if (!sck && prevSck && !csb && txRises >= 32)
                    io1 = pattern[((txRises - 32) / 8) % 4][7 - ((txRises - 32) % 8)];
                if (valid) validCycles++;
                if (valid && readyI) begin
                    if (rxCount < 16) rxBytes[rxCount] = data;
                    rxCount++;
                end
                if (done) doneCount++;
                if (busy) busyCycles++;
                if (!csb) csbLowCycles++;
            end
            prevSck = sck;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearAll();
        clearStats = 1'b1;
        @(posedge clk); #1;
        clearStats = 1'b0;
    endtask

    task automatic applyStimulus(input logic [23:0] addr, input int len);
        addrI  = addr;
        lenI   = LEN_W'(len);
        startI = 1'b1;
        @(posedge clk); #1;
        startI = 1'b0;
    endtask

    task automatic checkInstance(input string label, input int inst, input vec_t v,
                                 input int expPeriod, input int doneCount, input int rxCount,
                                 input int rises, input int validCycles, input int csbLow,
                                 input int busyCycles, input int period, input logic [31:0] mosi,
                                 input logic busy, input logic csb, input logic [7:0] bytes [16]);
        string p;
        p = $sformatf("%s i%0d", label, inst);
        check({p, " done pulses"}, doneCount, 1);
        check({p, " byte count"}, rxCount, v.len);
        check({p, " sck rises"}, rises, v.expRises);
        check({p, " idle busy"}, busy, 1'b0);
        check({p, " idle csb"}, csb, 1'b1);
        if (v.len > 0) begin
            check({p, " mosi cmd+addr"}, mosi, v.expMosi);
            check({p, " sck period"}, period, expPeriod);
        end else begin
            check({p, " csb low cycles"}, csbLow, 0);
            check({p, " busy cycles"}, busyCycles, 3);
        end
        if (v.stall == 0) check({p, " valid cycles"}, validCycles, v.len);
        for (int k = 0; k < v.len && k < 16; k++)
            check($sformatf("%s byte%0d", p, k), bytes[k], pattern[k % 4]);
    endtask

    task automatic checkOutput(input string label, input vec_t v);
        checkInstance(label, 0, v, 4, u[0].doneCount, u[0].rxCount, u[0].rises, u[0].validCycles,
                      u[0].csbLowCycles, u[0].busyCycles, u[0].period, u[0].mosi, u[0].busy,
                      u[0].csb, u[0].rxBytes);
        checkInstance(label, 1, v, 2, u[1].doneCount, u[1].rxCount, u[1].rises, u[1].validCycles,
                      u[1].csbLowCycles, u[1].busyCycles, u[1].period, u[1].mosi, u[1].busy,
                      u[1].csb, u[1].rxBytes);
        checkInstance(label, 2, v, 8, u[2].doneCount, u[2].rxCount, u[2].rises, u[2].validCycles,
                      u[2].csbLowCycles, u[2].busyCycles, u[2].period, u[2].mosi, u[2].busy,
                      u[2].csb, u[2].rxBytes);
    endtask

    // Runs one table entry: optional consumer stall after the first byte of
    // instance 0, optional extra start pulse while everything is busy.
    task automatic runVector(input string label, input vec_t v);
        bit stallOn, stallDone, injected, allDone;
        int stallCyc, risesMark, risesEnd, sckHigh;
        stallOn = 0; stallDone = 0; injected = 0; allDone = 0;
        stallCyc = 0; risesMark = 0; risesEnd = -1; sckHigh = 0;
        clearAll();
        readyI = 1'b1;
        applyStimulus(v.addr, v.len);
        for (int c = 0; c < 4000 && !allDone; c++) begin
            @(posedge clk); #1;
            startI = 1'b0;
            if (v.inject >= 0 && !injected && u[0].txRises >= v.inject) begin
                addrI    = 24'h777777;
                lenI     = 16'd9;
                startI   = 1'b1;
                injected = 1'b1;
            end
            if (v.stall > 0 && !stallOn && !stallDone && u[0].valid) begin
                readyI  = 1'b0;
                stallOn = 1'b1;
            end else if (stallOn) begin
                stallCyc++;
                if (stallCyc == 6) risesMark = u[0].rises;
                if (stallCyc > 6 && u[0].sck) sckHigh++;
                if (stallCyc == v.stall) begin
                    risesEnd  = u[0].rises;
                    readyI    = 1'b1;
                    stallOn   = 1'b0;
                    stallDone = 1'b1;
                end
            end
            allDone = (u[0].doneCount > 0) && (u[1].doneCount > 0) && (u[2].doneCount > 0);
        end
        startI = 1'b0;
        readyI = 1'b1;
        check({label, " finished in budget"}, allDone, 1'b1);
        if (v.stall > 0) begin
            check({label, " stall reached"}, stallDone, 1'b1);
            check({label, " no sck rise in stall"}, risesEnd, risesMark);
            check({label, " sck high in stall"}, sckHigh, 0);
        end
        if (v.inject >= 0) check({label, " start injected"}, injected, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput(label, v);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        pattern[0] = 8'hDE; pattern[1] = 8'hAD; pattern[2] = 8'hBE; pattern[3] = 8'hEF;
        vecs[0] = '{24'h000100, 4, 0,  -1, 32'h03000100, 64};
        vecs[1] = '{24'h000100, 4, 50, -1, 32'h03000100, 64};
        vecs[2] = '{24'h000000, 0, 0,  -1, 32'h00000000, 0};
        vecs[3] = '{24'h000100, 4, 0,  20, 32'h03000100, 64};
        vecs[4] = '{24'hABCDEF, 6, 0,  -1, 32'h03ABCDEF, 80};

        clearStats = 1'b1;
        rst = 1'b1; startI = 1'b0; addrI = '0; lenI = '0; readyI = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset csb", u[0].csb, 1'b1);
        check("reset sck", u[0].sck, 1'b0);
        check("reset io0", u[0].io0, 1'b0);
        check("reset valid", u[0].valid, 1'b0);
        check("reset data", u[0].data, 8'h00);
        check("reset busy", u[0].busy, 1'b0);
        check("reset done", u[0].done, 1'b0);
        clearStats = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        // A start held through the done cycle is taken only one cycle later.
        clearAll();
        applyStimulus(24'h0, 0);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (u[0].done) found = 1;
        end
        check("done-cycle done seen", found, 1'b1);
        startI = 1'b1; lenI = '0;
        @(posedge clk); #1;
        check("done-cycle start ignored", u[0].busy, 1'b0);
        @(posedge clk); #1;
        check("start after done accepted", u[0].busy, 1'b1);
        startI = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #1;
            if (u[0].done) found = 1;
        end
        check("second zero-length done", found, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of the address phase, then a clean read.
        clearAll();
        applyStimulus(24'h000100, 4);
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(posedge clk); #1;
            if (u[0].txRises >= 18) found = 1;
        end
        check("rst reached addr bit 10", found, 1'b1);
        check("rst in addr phase csb low", u[0].csb, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid rst csb", u[0].csb, 1'b1);
        check("mid rst sck", u[0].sck, 1'b0);
        check("mid rst valid", u[0].valid, 1'b0);
        check("mid rst busy", u[0].busy, 1'b0);
        check("mid rst i1 csb", u[1].csb, 1'b1);
        check("mid rst i2 busy", u[2].busy, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        runVector("after rst", vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
